// File: rtl/seg7_scan_driver_pkg.sv
// Shared display constants, scan states and the active-low hex-to-segment table
// used by every seven-segment block.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_e;

  // Active-low cathodes packed as {g,f,e,d,c,b,a}; a 0 bit lights that segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-slot guard band,
// brightness duty control and a frame-synchronous shadow/display register pair.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int GUARD      = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] VALUE,
  input  logic [3:0]  DP_IN,
  input  logic [3:0]  BLANK_IN,
  input  logic [2:0]  BRIGHT,
  input  logic        LOAD,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        FRAME
);

  localparam logic [PRESCALE_W-1:0] CNT_ONE   = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] GUARD_CNT = PRESCALE_W'(GUARD);

  scan_state_e           state;
  scan_state_e           state_next;
  logic [PRESCALE_W-1:0] cnt;
  logic                  tc;
  logic [1:0]            idx;

  logic [15:0] sh_val;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_blank;
  logic [15:0] disp_val;
  logic [3:0]  disp_dp;
  logic [3:0]  disp_blank;
  logic [2:0]  bright_q;
  logic [2:0]  bright_eff;

  logic [3:0]  nibble;
  logic [6:0]  dec_seg;
  logic        lit;
  logic        frame_nxt;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;

  assign tc  = &cnt;
  assign idx = state;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= DIG0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (tc) begin
      case (state)
        DIG0:    state_next = DIG1;
        DIG1:    state_next = DIG2;
        DIG2:    state_next = DIG3;
        default: state_next = DIG0;
      endcase
    end
  end

  // At counter 0 the live BRIGHT input is used so a zero guard band still
  // sees this slot's level rather than the previous slot's.
  assign bright_eff = (cnt == '0) ? BRIGHT : bright_q;
  assign nibble     = disp_val[{idx, 2'b00} +: 4];
  assign lit        = (cnt >= GUARD_CNT)
                   && (cnt[PRESCALE_W-1 -: 3] <= bright_eff)
                   && !disp_blank[idx];
  assign frame_nxt  = (state == DIG3) && tc;

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = dec_seg;
      dp_nxt  = ~disp_dp[idx];
    end
  end

  // LOAD is a bare strobe with no handshake: every cycle it is high the shadow
  // takes the inputs. The display only picks up the shadow on the DIG3->DIG0
  // edge, so a LOAD on that same edge lands in the shadow and waits a frame.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt        <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= 4'b1111;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_blank <= 4'b1111;
      bright_q   <= '0;
      AN         <= AN_OFF;
      SEG        <= SEG_OFF;
      DP         <= 1'b1;
      FRAME      <= 1'b0;
    end else begin
      cnt <= cnt + CNT_ONE;
      if (LOAD) begin
        sh_val   <= VALUE;
        sh_dp    <= DP_IN;
        sh_blank <= BLANK_IN;
      end
      if (frame_nxt) begin
        disp_val   <= sh_val;
        disp_dp    <= sh_dp;
        disp_blank <= sh_blank;
      end
      if (cnt == '0) begin
        bright_q <= BRIGHT;
      end
      AN    <= an_nxt;
      SEG   <= seg_nxt;
      DP    <= dp_nxt;
      FRAME <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with a 16-cycle slot and 64-cycle frame.
module tb_seg7_scan_driver;

  localparam int PW = 4;
  localparam int GD = 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] VALUE = '0;
  logic [3:0]  DP_IN = '0;
  logic [3:0]  BLANK_IN = '0;
  logic [2:0]  BRIGHT = '0;
  logic        LOAD = 1'b0;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        FRAME;

  seg7_scan_driver #(.PRESCALE_W(PW), .GUARD(GD)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .VALUE    (VALUE),
    .DP_IN    (DP_IN),
    .BLANK_IN (BLANK_IN),
    .BRIGHT   (BRIGHT),
    .LOAD     (LOAD),
    .AN       (AN),
    .SEG      (SEG),
    .DP       (DP),
    .FRAME    (FRAME)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int          n_total = 0;
  int          n_bad = 0;
  logic [28:0] exp_q[$];  // {cycle[15:0], an[3:0], seg[6:0], dp, frame}
  int          k = 0;     // posedges since reset release

  // Reference view of the shadow and display registers plus slot brightness.
  logic [15:0] ms_val, md_val;
  logic [3:0]  ms_dp, md_dp, ms_blank, md_blank;
  logic [2:0]  mb;

  localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0};

  // Active-high gfedcba shapes, inverted on return for the active-low pins.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] on;
    case (d)
      4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
      4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
      4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
      4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  task automatic check(input string name, input logic [12:0] act,
                       input logic [12:0] exp, input int cyc);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got an=%b seg=%h dp=%b frame=%b expected an=%b seg=%h dp=%b frame=%b",
               name, cyc, act[12:9], act[8:2], act[1], act[0],
               exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [28:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scan", {AN, SEG, DP, FRAME}, e[12:0], int'(e[28:13]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_model();
    ms_val = '0; ms_dp = '0; ms_blank = 4'b1111;
    md_val = '0; md_dp = '0; md_blank = 4'b1111;
    mb = '0;
  endtask

  // Called just after a negedge with this cycle's inputs applied: pushes the
  // output expected after the coming posedge, then advances the reference.
  task automatic tick();
    int j, c, s;
    logic lit;
    logic [12:0] w;
    j = k + 1;
    c = k % 16;
    s = (k / 16) % 4;
    if (c == 0) mb = BRIGHT;
    lit = (c >= GD) && ((c / 2) <= int'(mb)) && !md_blank[s];
    if (lit) w = {~(4'b0001 << s), seg_of(md_val[s*4 +: 4]), ~md_dp[s], 1'b0};
    else     w = DARK;
    w[0] = (j % 64 == 0);
    exp_q.push_back({j[15:0], w});
    if (j % 64 == 0) begin
      md_val = ms_val; md_dp = ms_dp; md_blank = ms_blank;
    end
    if (LOAD) begin
      ms_val = VALUE; ms_dp = DP_IN; ms_blank = BLANK_IN;
    end
    @(negedge CLK);
    k = j;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until(input int pos);
    int spent;
    spent = 0;
    while ((k % 64 != pos) && (spent < 200)) begin
      tick();
      spent++;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    VALUE = v; DP_IN = d; BLANK_IN = b; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_model();
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_state", {AN, SEG, DP, FRAME}, DARK, 0);

    // Frame 0 stays dark (display blanked by reset, no FRAME); 1234 shows in frame 1.
    RESET = 1'b1;
    k = 0;
    BRIGHT = 3'd7;
    run(3);
    do_load(16'h1234, 4'h0, 4'h0);
    run_until(0);
    run(64);

    // Duty levels: one lit cycle per slot, then seven.
    BRIGHT = 3'd0;
    run(64);
    BRIGHT = 3'd3;
    run(64);

    // Mid-frame LOAD waits for the next frame; LOAD on the DIG0-entry edge waits two.
    BRIGHT = 3'd7;
    run_until(21);
    do_load(16'hABCD, 4'h0, 4'h0);
    run_until(63);
    do_load(16'h5678, 4'h0, 4'h0);
    run(64);
    run(64);

    // Blanked digits 0 and 2, decimal point on digit 3 only.
    do_load(16'h9EF0, 4'b1000, 4'b0101);
    run_until(0);
    run(64);

    // Reset at counter 9 of DIG2: outputs go dark without waiting for a clock.
    run_until(41);
    RESET = 1'b0;
    #1;
    check("async_reset", {AN, SEG, DP, FRAME}, DARK, k);
    reset_model();
    repeat (2) @(negedge CLK);
    check("reset_hold", {AN, SEG, DP, FRAME}, DARK, k);
    RESET = 1'b1;
    k = 0;
    run(128);
    do_load(16'h90E6, 4'b0001, 4'h0);
    run_until(0);
    run(64);

    @(posedge CLK);
    #2;
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16: width of the slot counter; one digit slot lasts 2^PRESCALE_W cycles.
REQ-002 SHALL have parameter GUARD, default 64: number of cycles at each slot start during which all anodes are off (anti-ghosting); GUARD < 2^(PRESCALE_W-3).
REQ-003 SHALL have port CLK, input, 1: the single clock; all state is on its rising edge.
REQ-004 SHALL have port RESET, input, 1: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port VALUE, input, 16: hex digits; digit i = VALUE[4i+3:4i].
REQ-006 SHALL have port DP_IN, input, 4: decimal point request per digit, 1 = lit.
REQ-007 SHALL have port BLANK_IN, input, 4: per-digit blank, 1 = digit dark.
REQ-008 SHALL have port BRIGHT, input, 3: duty level 0..7.
REQ-009 SHALL have port LOAD, input, 1: single-cycle strobe; captures VALUE/DP_IN/BLANK_IN into the shadow register.
REQ-010 SHALL have port AN, output, 4: active-low anodes; AN[i] selects digit i.
REQ-011 SHALL have port SEG, output, 7: active-low cathodes {CG,CF,CE,CD,CC,CB,CA}.
REQ-012 SHALL have port DP, output, 1: active-low decimal point cathode.
REQ-013 SHALL have port FRAME, output, 1: one-cycle pulse at the start of each frame (digit 0 slot).

Function
REQ-014 Shadow register SHALL update on every cycle LOAD=1; LOAD=0 holds it.
REQ-015 Display register SHALL copy the shadow only in the cycle the scan enters digit 0, so a frame never mixes old and new data; a LOAD in that same cycle takes effect the following frame.
REQ-016 Slot counter SHALL count 0..2^PRESCALE_W-1 and wrap; at terminal count the digit index SHALL advance 0->1->2->3->0.
REQ-017 The FSM SHALL have states DIG0..DIG3; the only transition is DIGi->DIG(i+1 mod 4) at terminal count; no other event changes state.
REQ-018 BRIGHT SHALL be sampled once per slot (at counter=0) and held for that slot.
REQ-019 Anode i SHALL be driven low only when state=DIGi, counter >= GUARD, counter[PRESCALE_W-1 -: 3] <= sampled BRIGHT, and display blank bit i = 0; otherwise AN = 4'b1111.
REQ-020 SEG SHALL be the hex decode (0-9, A, b, C, d, E, F) of the current digit's nibble; DP = ~dp bit; both forced all-high (dark) whenever no anode is on.
REQ-021 AN, SEG, DP and FRAME SHALL be registered: exactly one cycle after the counter/state producing them.
REQ-022 FRAME SHALL be high for exactly one cycle, the cycle after the DIG3->DIG0 transition.
REQ-023 BRIGHT=7 SHALL give on-time 2^PRESCALE_W - GUARD cycles per slot; BRIGHT=0 SHALL give 2^(PRESCALE_W-3) - GUARD.

Reset
REQ-024 RESET low SHALL asynchronously force: counter=0, state=DIG0, shadow and display VALUE/DP=0, BLANK=4'b1111, sampled BRIGHT=0, AN=4'b1111, SEG=7'h7F, DP=1, FRAME=0.
REQ-025 After RESET rises, the first slot SHALL be DIG0 starting at counter=0; no FRAME pulse for that first entry.
REQ-026 RESET asserted mid-slot SHALL discard partial scan state; pending LOAD data not yet in the display register is lost.

Structure
REQ-027 The hex-to-segment table and active-low constants (SEG_OFF=7'h7F, AN_OFF=4'hF) SHALL live in a shared include file used by all display blocks.
REQ-028 The decode SHALL be a combinational sub-module seg7_hex_decode (4-bit in, 7-bit active-low out); everything else is in seg7_scan_driver.

Verification (PRESCALE_W=4, GUARD=1: slot 16 cycles, frame 64)
REQ-029 Reset, LOAD VALUE=16'h1234, BLANK_IN=0, BRIGHT=7 -> from next frame: AN=1110 showing SEG of 4 for cycles 1..15 of slot, then 1101 showing 3, 1011 showing 2, 0111 showing 1; AN=1111 at counter 0 of every slot.
REQ-030 BRIGHT=0 -> each anode low for exactly 1 cycle per slot (counter=1); BRIGHT=3 -> 7 cycles (counter 1..7).
REQ-031 LOAD VALUE=16'hABCD mid-frame -> current frame still shows old digits; new digits appear from next DIG0; LOAD in the DIG0-entry cycle appears one frame later.
REQ-032 BLANK_IN=4'b0101, DP_IN=4'b1000 -> AN0/AN2 never low; DP=0 only while AN3 low.
REQ-033 FRAME pulses once per 64 cycles, never in the first frame after reset.
REQ-034 Assert RESET at counter 9 of DIG2 -> outputs dark immediately (asynchronous); after release scan restarts at DIG0 with BLANK=1111 until next LOAD and frame.
